// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the multi-channel switch debouncer.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LOW          = 2'b00,
    ST_CONFIRM_HIGH = 2'b01,
    ST_HIGH         = 2'b10,
    ST_CONFIRM_LOW  = 2'b11
  } db_state_e;

  // 10 ms of stable level at 5 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  function automatic logic level_of(input db_state_e st);
    logic lvl;
    case (st)
      ST_HIGH,
      ST_CONFIRM_LOW: lvl = 1'b1;
      default:        lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Raw and debounced switch levels plus edge pulses between board and debouncer.
interface switch_debouncer_if #(
  parameter int WIDTH = 3
);

  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (
    output sw_in,
    input  sw_db,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_in,
    output sw_db,
    output sw_rise,
    output sw_fall
  );

endinterface

// File: rtl/switch_debouncer_channel.sv
// One debounced switch channel: 2-flop synchronizer, qualification FSM with
// stable-time counter, and registered level/edge-pulse outputs.
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_r;
  logic             sync_r;
  db_state_e        state_r;
  db_state_e        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             db_r;
  logic             rise_r;
  logic             fall_r;

  // Synchronizer for the asynchronous pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
    end
  end

  // Next-state and counter: any disagreement during confirmation drops back.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_LOW: begin
        cnt_nxt_s = CNT_ZERO;
        if (sync_r) state_nxt_s = ST_CONFIRM_HIGH;
        else        state_nxt_s = ST_LOW;
      end
      ST_CONFIRM_HIGH: begin
        if (!sync_r) begin
          state_nxt_s = ST_LOW;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_HIGH;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HIGH: begin
        cnt_nxt_s = CNT_ZERO;
        if (!sync_r) state_nxt_s = ST_CONFIRM_LOW;
        else         state_nxt_s = ST_HIGH;
      end
      ST_CONFIRM_LOW: begin
        if (sync_r) begin
          state_nxt_s = ST_HIGH;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_LOW;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_LOW;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_LOW;
      cnt_r   <= CNT_ZERO;
      db_r    <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      db_r    <= level_of(state_nxt_s);
      rise_r  <= (state_r == ST_CONFIRM_HIGH) && (state_nxt_s == ST_HIGH);
      fall_r  <= (state_r == ST_CONFIRM_LOW)  && (state_nxt_s == ST_LOW);
    end
  end

  assign db   = db_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent debounce_channel instances.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               CLK_5_MHZ,
  input  logic               CPU_RESETN,
  switch_debouncer_if.slave  sw
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  if ($bits(sw.sw_in) != WIDTH) begin : g_bad_width
    $error("switch_debouncer: interface width does not match WIDTH");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (CLK_5_MHZ),
      .rst_n(CPU_RESETN),
      .raw  (sw.sw_in[i]),
      .db   (sw.sw_db[i]),
      .rise (sw.sw_rise[i]),
      .fall (sw.sw_fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=3, DEBOUNCE_CYCLES=8.
module tb_switch_debouncer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  switch_debouncer_if #(.WIDTH(3)) sw_bus ();

  switch_debouncer #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .CLK_5_MHZ (clk),
    .CPU_RESETN(rst_n),
    .sw        (sw_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_db;
    rst_n = 1'b0;
    sw_bus.sw_in = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (sw_bus.sw_db !== 3'b000 || sw_bus.sw_rise !== 3'b000 || sw_bus.sw_fall !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs: db=%b rise=%b fall=%b, required all 000", sw_bus.sw_db, sw_bus.sw_rise, sw_bus.sw_fall);
      end
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp_db = (e == 10) ? 3'b111 : 3'b000;
      n_checks++;
      if (sw_bus.sw_db !== exp_db || sw_bus.sw_rise !== exp_db) begin
        n_fail++;
        $display("FAIL release_latency e=%0d: db=%b rise=%b, required %b", e, sw_bus.sw_db, sw_bus.sw_rise, exp_db);
      end
    end
    tick();
    n_checks++;
    if (sw_bus.sw_rise !== 3'b000 || sw_bus.sw_db !== 3'b111) begin
      n_fail++;
      $display("FAIL rise_one_cycle: db=%b rise=%b, required db=111 rise=000", sw_bus.sw_db, sw_bus.sw_rise);
    end
  endtask

  task automatic test_fall();
    logic [2:0] exp_db;
    sw_bus.sw_in = 3'b000;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp_db = (e == 10) ? 3'b000 : 3'b111;
      n_checks++;
      if (sw_bus.sw_db !== exp_db || sw_bus.sw_fall !== ((e == 10) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL fall_latency e=%0d: db=%b fall=%b, required db=%b", e, sw_bus.sw_db, sw_bus.sw_fall, exp_db);
      end
    end
    tick();
    n_checks++;
    if (sw_bus.sw_fall !== 3'b000) begin
      n_fail++;
      $display("FAIL fall_one_cycle: fall=%b, required 000", sw_bus.sw_fall);
    end
  endtask

  task automatic test_bounce();
    int rises;
    rises = 0;
    for (int seg = 0; seg < 10; seg++) begin
      sw_bus.sw_in = (seg % 2 == 0) ? 3'b001 : 3'b000;
      for (int c = 0; c < 3; c++) begin
        tick();
        n_checks++;
        if (sw_bus.sw_db !== 3'b000 || sw_bus.sw_rise !== 3'b000) begin
          n_fail++;
          $display("FAIL bounce_reject seg=%0d: db=%b rise=%b, required 000", seg, sw_bus.sw_db, sw_bus.sw_rise);
        end
      end
    end
    sw_bus.sw_in = 3'b001;
    for (int e = 0; e < 20; e++) begin
      tick();
      rises += int'(sw_bus.sw_rise[0]);
      if (e == 9) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b000) begin
          n_fail++;
          $display("FAIL bounce_early: db=%b, required 000", sw_bus.sw_db);
        end
      end
      if (e == 10) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b001) begin
          n_fail++;
          $display("FAIL bounce_settle: db=%b, required 001", sw_bus.sw_db);
        end
      end
    end
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL bounce_rise_count: got %0d pulses, required 1", rises);
    end
  endtask

  task automatic test_short_pulse();
    sw_bus.sw_in = 3'b011;
    for (int c = 0; c < 22; c++) begin
      if (c == 7) sw_bus.sw_in = 3'b001;
      tick();
      n_checks++;
      if (sw_bus.sw_db !== 3'b001 || sw_bus.sw_rise !== 3'b000 || sw_bus.sw_fall !== 3'b000) begin
        n_fail++;
        $display("FAIL short_reject c=%0d: db=%b rise=%b fall=%b, required 001/000/000", c, sw_bus.sw_db, sw_bus.sw_rise, sw_bus.sw_fall);
      end
    end
    sw_bus.sw_in = 3'b011;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 9) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b001 || sw_bus.sw_rise !== 3'b000) begin
          n_fail++;
          $display("FAIL qualify_early: db=%b rise=%b, required 001/000", sw_bus.sw_db, sw_bus.sw_rise);
        end
      end
      if (e == 10) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b011 || sw_bus.sw_rise !== 3'b010) begin
          n_fail++;
          $display("FAIL qualify_rise: db=%b rise=%b, required 011/010", sw_bus.sw_db, sw_bus.sw_rise);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    sw_bus.sw_in = 3'b010;
    for (int c = 0; c < 12; c++) tick();
    n_checks++;
    if (sw_bus.sw_db !== 3'b010) begin
      n_fail++;
      $display("FAIL simul_setup: db=%b, required 010", sw_bus.sw_db);
    end
    sw_bus.sw_in = 3'b001;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 9) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b010 || sw_bus.sw_rise !== 3'b000 || sw_bus.sw_fall !== 3'b000) begin
          n_fail++;
          $display("FAIL simul_early: db=%b rise=%b fall=%b, required 010/000/000", sw_bus.sw_db, sw_bus.sw_rise, sw_bus.sw_fall);
        end
      end
      if (e == 10) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b001 || sw_bus.sw_rise !== 3'b001 || sw_bus.sw_fall !== 3'b010) begin
          n_fail++;
          $display("FAIL simul_edges: db=%b rise=%b fall=%b, required 001/001/010", sw_bus.sw_db, sw_bus.sw_rise, sw_bus.sw_fall);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sw_bus.sw_in = 3'b101;
    // Eight edges put channel 2 into confirmation with count 5.
    for (int e = 0; e < 8; e++) tick();
    n_checks++;
    if (sw_bus.sw_db !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_pre: db=%b, required 001", sw_bus.sw_db);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (sw_bus.sw_db !== 3'b000 || sw_bus.sw_rise !== 3'b000 || sw_bus.sw_fall !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_clear: db=%b rise=%b fall=%b, required 000", sw_bus.sw_db, sw_bus.sw_rise, sw_bus.sw_fall);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e < 10) begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b000 || sw_bus.sw_rise !== 3'b000 || sw_bus.sw_fall !== 3'b000) begin
          n_fail++;
          $display("FAIL midreset_requalify e=%0d: db=%b rise=%b fall=%b, required 000", e, sw_bus.sw_db, sw_bus.sw_rise, sw_bus.sw_fall);
        end
      end else begin
        n_checks++;
        if (sw_bus.sw_db !== 3'b101 || sw_bus.sw_rise !== 3'b101) begin
          n_fail++;
          $display("FAIL midreset_rise: db=%b rise=%b, required 101/101", sw_bus.sw_db, sw_bus.sw_rise);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sw_bus.sw_in = 3'b000;
    test_reset();
    test_fall();
    test_bounce();
    test_short_pulse();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
